alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 The block SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-003 The block SHALL have ports: in_valid  in  1  request present; in_ready  out  1  request accepted this cycle when both high.
REQ-004 The block SHALL have ports: in_op  in  3  operation; in_a  in  32  first operand; in_b  in  32  second operand.
REQ-005 The block SHALL have ports: add_x  out  32, add_y  out  32, add_cin  out  1, add_sub  out  1; these drive the 32-bit adder/subtracter.
REQ-006 The block SHALL have ports: add_z  in  32, add_ovf  in  1, add_carry  in  1; these are the adder result, overflow and carry/borrow.
REQ-007 The block SHALL have ports: out_valid  out  1, out_ready  in  1, out_result  out  32, out_we  out  1 (result to be pushed to the stack).
REQ-008 The block SHALL have ports: flags  out  4  {N,Z,V,C}; flag_ld  in  1; flag_in  in  4  flag load value.

Function
REQ-009 The block SHALL decode in_op as follows:
- 000 ADD: cin=0, sub=0.
- 001 SUB: cin=0, sub=1.
- 010 ADC: cin=C, sub=0.
- 011 SBC: cin=C (borrow-in), sub=1.
- 100 CMP: same as SUB, but out_we=0.
- 101-111: reserved.
REQ-010 The block SHALL implement a state machine with states IDLE, EXEC and DONE, entering IDLE on reset.
REQ-011 in_ready SHALL be 1 only in IDLE; no request SHALL be accepted in EXEC or DONE.
REQ-012 On an accept edge, the block SHALL register in_a into add_x, in_b into add_y, and the decoded cin/sub into add_cin/add_sub, then go to EXEC.
REQ-013 For ADC/SBC, add_cin SHALL use the C flag value as it stands at the accept edge.
REQ-014 add_x, add_y, add_cin and add_sub SHALL stay constant from the accept edge until the next accept.
REQ-015 In EXEC, the block SHALL take one full cycle for the adder to settle, then at the next edge capture the following and go to DONE:
- out_result = add_z.
- C = add_carry.
- V = add_ovf.
- Z = (add_z == 0).
- N = add_z[31].
REQ-016 Latency: with an accept at edge k, out_valid SHALL be 1 after edge k+1; the minimum issue interval SHALL be 3 cycles.
REQ-017 In DONE, out_valid=1, and out_result and out_we SHALL be held stable until out_ready=1 at an edge, after which the state SHALL return to IDLE.
REQ-018 If out_ready is held 1, the block SHALL spend exactly one cycle in DONE.
REQ-019 out_we SHALL be 1 for ADD/SUB/ADC/SBC and 0 for CMP and reserved ops.
REQ-020 A reserved op SHALL still traverse EXEC/DONE with out_result=0 and out_we=0, and SHALL leave the flags unchanged.
REQ-021 flag_ld=1 at an edge SHALL load flags from flag_in.
REQ-022 If flag_ld coincides with the EXEC capture edge, the capture SHALL win and flag_ld SHALL be ignored.
REQ-023 Arithmetic SHALL be 32-bit modulo 2^32 with no saturation; C after a subtract SHALL mean borrow (1 when the unsigned result is less than 0).
REQ-024 in_valid SHALL be ignored outside IDLE; no request SHALL be buffered or dropped with a side effect.

Reset
REQ-025 On asserted rst, the block SHALL immediately set state=IDLE, in_ready=1, out_valid=0, out_we=0, out_result=0, add_x=0, add_y=0, add_cin=0, add_sub=0, flags=0000.
REQ-026 An rst assertion in EXEC or DONE SHALL abort the operation with no result delivered and no flag update.
REQ-027 After rst deasserts, the first request SHALL be accepted at the first rising edge with in_valid=1.

Verification
REQ-028 ADD 0x7FFFFFFF + 0x00000001 -> out_result=0x80000000, out_we=1, flags N=1 Z=0 V=1 C=0, out_valid two cycles after accept.
REQ-029 SUB 5 - 5, then SBC 0 - 0 -> first gives 0 with Z=1 C=0; second gives 0x00000000 with add_cin=0 driven.
REQ-030 SUB 0 - 1 -> 0xFFFFFFFF with N=1 C=1; then SBC 0 - 0 -> add_cin=1, result 0xFFFFFFFF, C=1.
REQ-031 64-bit add: ADD 0xFFFFFFFF + 1 giving 0 with C=1, then ADC 0 + 0 -> result 1, C=0.
REQ-032 CMP 3, 7 -> out_we=0, out_result=0xFFFFFFFC, N=1 C=1; hold out_ready=0 for 4 cycles -> outputs stable and in_ready=0 throughout.
REQ-033 Assert flag_ld with flag_in=1111 on the capture edge of ADD 1+1 -> flags=0000; assert rst in EXEC -> out_valid stays 0 and all outputs reset.

Source files
------------

// File: rtl/alu_issue_if.sv
// Bundle of request, adder, result and flag signals between the ALU issue stage
// and its environment. The slave modport is the issue stage itself.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_cin;
  logic        add_sub;
  logic [31:0] add_z;
  logic        add_ovf;
  logic        add_carry;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_we;

  logic [3:0]  flags;
  logic        flag_ld;
  logic [3:0]  flag_in;

  modport master (
    output in_valid, in_op, in_a, in_b, add_z, add_ovf, add_carry, out_ready, flag_ld, flag_in,
    input  in_ready, add_x, add_y, add_cin, add_sub, out_valid, out_result, out_we, flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, add_z, add_ovf, add_carry, out_ready, flag_ld, flag_in,
    output in_ready, add_x, add_y, add_cin, add_sub, out_valid, out_result, out_we, flags
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage for an external 32-bit adder/subtracter: latches operands, waits one
// cycle for the adder to settle, then presents the result and updates {N,Z,V,C}.
module alu_issue_stage (
  input logic         clk,
  input logic         rst,
  alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] x_q, y_q, result_q;
  logic        cin_q, sub_q, we_q, out_we_q, rsvd_q;
  logic [3:0]  flags_q;

  logic        dec_cin, dec_sub, dec_we, dec_rsvd;
  logic        accept;

  assign accept = (state_q == StIdle) && bus.in_valid;

  // Carry-in for ADC/SBC comes from the C flag as it stands at the accept edge.
  always_comb begin
    dec_cin  = 1'b0;
    dec_sub  = 1'b0;
    dec_we   = 1'b0;
    dec_rsvd = 1'b0;
    unique case (bus.in_op)
      3'b000: dec_we = 1'b1;
      3'b001: begin dec_sub = 1'b1; dec_we = 1'b1; end
      3'b010: begin dec_cin = flags_q[0]; dec_we = 1'b1; end
      3'b011: begin dec_cin = flags_q[0]; dec_sub = 1'b1; dec_we = 1'b1; end
      3'b100: dec_sub = 1'b1;
      default: dec_rsvd = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      cin_q  <= 1'b0;
      sub_q  <= 1'b0;
      we_q   <= 1'b0;
      rsvd_q <= 1'b0;
    end else if (accept) begin
      x_q    <= bus.in_a;
      y_q    <= bus.in_b;
      cin_q  <= dec_cin;
      sub_q  <= dec_sub;
      we_q   <= dec_we;
      rsvd_q <= dec_rsvd;
    end
  end

  // Result and flags are captured at the end of the single EXEC cycle; a flag load
  // on that edge loses, and a reserved op leaves the flags untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      out_we_q <= 1'b0;
      flags_q  <= '0;
    end else if (state_q == StExec) begin
      if (rsvd_q) begin
        result_q <= '0;
        out_we_q <= 1'b0;
      end else begin
        result_q <= bus.add_z;
        out_we_q <= we_q;
        flags_q  <= {bus.add_z[31], (bus.add_z == 32'd0), bus.add_ovf, bus.add_carry};
      end
    end else if (bus.flag_ld) begin
      flags_q <= bus.flag_in;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_result = result_q;
  assign bus.out_we     = out_we_q;
  assign bus.add_x      = x_q;
  assign bus.add_y      = y_q;
  assign bus.add_cin    = cin_q;
  assign bus.add_sub    = sub_q;
  assign bus.flags      = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural adder/subtracter attached.
module tb_alu_issue_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: subtract produces a borrow in bit 32, add a carry-out.
  logic [32:0] sum;
  always_comb begin
    if (bus.add_sub) sum = {1'b0, bus.add_x} - {1'b0, bus.add_y} - {32'd0, bus.add_cin};
    else             sum = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {32'd0, bus.add_cin};
    bus.add_z     = sum[31:0];
    bus.add_carry = sum[32];
    if (bus.add_sub)
      bus.add_ovf = (bus.add_x[31] != bus.add_y[31]) && (sum[31] != bus.add_x[31]);
    else
      bus.add_ovf = (bus.add_x[31] == bus.add_y[31]) && (sum[31] != bus.add_x[31]);
  end

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chkw(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic chkf(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    chkw(tag, {28'd0, obs}, {28'd0, exp});
  endtask

  // One full transaction: accept, EXEC, DONE (optionally stalled), back to IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic exp_cin, input logic [31:0] exp_res,
                        input logic exp_we, input logic [3:0] exp_flags, input int hold,
                        input logic ld_on_capture);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chkb({tag, ".exec_in_ready"}, bus.in_ready, 1'b0);
    chkb({tag, ".exec_out_valid"}, bus.out_valid, 1'b0);
    chkw({tag, ".add_x"}, bus.add_x, a);
    chkw({tag, ".add_y"}, bus.add_y, b);
    chkb({tag, ".add_cin"}, bus.add_cin, exp_cin);
    if (ld_on_capture) begin
      bus.flag_ld = 1'b1;
      bus.flag_in = 4'b1111;
    end
    @(posedge clk);
    #1;
    bus.flag_ld = 1'b0;
    chkb({tag, ".out_valid"}, bus.out_valid, 1'b1);
    chkw({tag, ".out_result"}, bus.out_result, exp_res);
    chkb({tag, ".out_we"}, bus.out_we, exp_we);
    chkf({tag, ".flags"}, bus.flags, exp_flags);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      chkb({tag, ".hold_out_valid"}, bus.out_valid, 1'b1);
      chkb({tag, ".hold_in_ready"}, bus.in_ready, 1'b0);
      chkw({tag, ".hold_result"}, bus.out_result, exp_res);
      chkb({tag, ".hold_we"}, bus.out_we, exp_we);
      chkw({tag, ".hold_add_x"}, bus.add_x, a);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chkb({tag, ".idle_out_valid"}, bus.out_valid, 1'b0);
    chkb({tag, ".idle_in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    bus.flag_ld   = 1'b0;
    bus.flag_in   = 4'd0;

    #3;
    chkb("rst.in_ready", bus.in_ready, 1'b1);
    chkb("rst.out_valid", bus.out_valid, 1'b0);
    chkb("rst.out_we", bus.out_we, 1'b0);
    chkw("rst.out_result", bus.out_result, 32'd0);
    chkw("rst.add_x", bus.add_x, 32'd0);
    chkw("rst.add_y", bus.add_y, 32'd0);
    chkb("rst.add_cin", bus.add_cin, 1'b0);
    chkb("rst.add_sub", bus.add_sub, 1'b0);
    chkf("rst.flags", bus.flags, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // flags are {N,Z,V,C}
    run_op("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1,
           4'b1010, 0, 1'b0);
    run_op("sub_eq", 3'b001, 32'd5, 32'd5, 1'b0, 32'd0, 1'b1, 4'b0100, 0, 1'b0);
    run_op("sbc_c0", 3'b011, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 4'b0100, 0, 1'b0);
    run_op("sub_brw", 3'b001, 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 4'b1001, 0, 1'b0);
    run_op("sbc_c1", 3'b011, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b1001, 0, 1'b0);
    run_op("add_lo", 3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 4'b0101, 0, 1'b0);
    run_op("adc_hi", 3'b010, 32'd0, 32'd0, 1'b1, 32'd1, 1'b1, 4'b0000, 0, 1'b0);
    run_op("cmp", 3'b100, 32'd3, 32'd7, 1'b0, 32'hFFFF_FFFC, 1'b0, 4'b1001, 4, 1'b0);
    run_op("rsvd", 3'b101, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0, 4'b1001, 0, 1'b0);

    @(negedge clk);
    bus.flag_ld = 1'b1;
    bus.flag_in = 4'b1111;
    @(posedge clk);
    #1;
    bus.flag_ld = 1'b0;
    chkf("flag_ld_idle", bus.flags, 4'b1111);
    run_op("adc_ld_c", 3'b010, 32'd1, 32'd1, 1'b1, 32'd3, 1'b1, 4'b0000, 0, 1'b0);
    run_op("ld_vs_cap", 3'b000, 32'd1, 32'd1, 1'b0, 32'd2, 1'b1, 4'b0000, 0, 1'b1);

    // Reset during EXEC aborts without delivering a result.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b000;
    bus.in_a     = 32'h1234_5678;
    bus.in_b     = 32'h1111_1111;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chkw("abort.add_x_pre", bus.add_x, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chkb("abort.out_valid", bus.out_valid, 1'b0);
    chkb("abort.in_ready", bus.in_ready, 1'b1);
    chkw("abort.add_x", bus.add_x, 32'd0);
    chkw("abort.out_result", bus.out_result, 32'd0);
    chkf("abort.flags", bus.flags, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chkb("abort.post_valid", bus.out_valid, 1'b0);
    end
    run_op("post_rst", 3'b000, 32'd2, 32'd3, 1'b0, 32'd5, 1'b1, 4'b0000, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
